evt_crossbar_dst_dev: RTL
=========================

// Module: evt_crossbar_dst_dev
// PURPOSE
//  Destination-side endpoint of the event crossbar: takes one upstream event stream and multicasts each event to
//  a masked subset of SRC_PORTS crossbar source devices. Holds the event until every targeted port has handshaken,
//  then emits a one-cycle clean pulse that unmasks the source devices' valid. Sits between producer and crossbar.
// PARAMETERS
//  T          logic  event payload type
//  SRC_PORTS  4      number of crossbar source-device ports fed (>=1)
//  CNT_WIDTH  16     width of statistics counters (only with EVT_XBAR_DST_CNT_EN)
// PORTS
//  clk_i       in   1               clock
//  rst_ni      in   1               asynchronous active-low reset
//  data_i      in   T               upstream event payload
//  valid_i     in   1               upstream valid
//  ready_o     out  1               upstream ready
//  dst_mask_i  in   SRC_PORTS       target ports for the event on data_i; sampled with data_i
//  data_o      out  T[SRC_PORTS]    payload to each port (all carry the same held event)
//  valid_o     out  SRC_PORTS       per-port valid
//  ready_i     in   SRC_PORTS       per-port ready
//  clean_o     out  1               1-cycle pulse: all targeted ports accepted the held event
//  busy_o      out  1               event held (state DELIVER)
//  evt_cnt_o   out  CNT_WIDTH       delivered events (EVT_XBAR_DST_CNT_EN only)
//  drop_cnt_o  out  CNT_WIDTH       events dropped on empty mask (EVT_XBAR_DST_CNT_EN only)
// BEHAVIOUR
//  - Clock clk_i; reset rst_ni asynchronous, active-low. Reset: state IDLE, pend_q=0, data_q='0, valid_o=0,
//    clean_o=0, busy_o=0, ready_o=1, counters 0. Reset mid-delivery discards the held event; no clean pulse.
//  - Registers: data_q (T), pend_q (SRC_PORTS), state {IDLE, DELIVER}.
//  - data_o[k]=data_q for all k; valid_o[k]=pend_q[k] in DELIVER, else 0. Payload stable while any valid_o high.
//  - Handshake on port k: valid_o[k] && ready_i[k]. Each cycle in DELIVER: pend_q <= pend_q & ~ready_i.
//    Accepted ports drop valid next cycle (never deliver twice); remaining ports keep valid until accepted.
//  - last = DELIVER && ((pend_q & ~ready_i) == 0). clean_o = last (combinational, same cycle as final handshake).
//  - ready_o = (state==IDLE) || last. Combinational path ready_i -> ready_o is intended (back-to-back throughput).
//  - Upstream accept (valid_i && ready_o):
//     |dst_mask_i!=0 -> data_q<=data_i, pend_q<=dst_mask_i, state<=DELIVER (valid_o rises next cycle; latency 1).
//     dst_mask_i==0  -> event consumed and dropped; pend_q<=0, state<=IDLE; no valid_o, no clean_o.
//  - last with no new accept -> state<=IDLE, pend_q<=0. last with new accept -> reload, stay DELIVER (1 evt/cycle max).
//  - dst_mask_i bits are only meaningful while valid_i; ignored otherwise.
//  - Ports with ready_i high but pend_q[k]=0 have no effect. SRC_PORTS=1 degenerates to a 1-deep pipeline register.
//  - busy_o = (state==DELIVER).
// CONFIGURATION
//  EVT_XBAR_DST_CNT_EN defined: evt_cnt_o +1 on every clean_o; drop_cnt_o +1 on every empty-mask accept;
//   both saturate at all-ones, cleared only by reset.
//  Not defined: evt_cnt_o/drop_cnt_o ports absent, no counter logic.
// STRUCTURE
//  Package evt_xbar_pkg: state enum evt_xbar_dst_state_e {IDLE, DELIVER}; default CNT_WIDTH constant.
//  Sub-module evt_xbar_sat_cnt (saturating up-counter, inc/clear, WIDTH param), instantiated twice under macro.
//  All remaining logic flat in this module.
// TESTING
//  1 Single multicast: SRC_PORTS=4, data_i=8'hA5, dst_mask_i=4'b1011, all ready_i=1 -> valid_o=4'b1011 one cycle
//    after accept, clean_o=1 that cycle, ready_o=1, next cycle IDLE.
//  2 Staggered ready: mask 4'b0111, ready_i[0] cycle1, [2] cycle3, [1] cycle5 -> valid_o 0111->0110->0010->0000;
//    clean_o only cycle5; ready_o=0 cycles 1-4; data_o=held value throughout.
//  3 Back-to-back: stream 0x01,0x02,0x03 mask 4'b1111, ready_i=4'hF -> one event per cycle, 3 clean pulses, no gaps.
//  4 Empty mask: valid_i with dst_mask_i=0 -> ready_o=1, no valid_o, no clean_o; drop_cnt_o=1 with macro.
//  5 Reset mid-delivery: mask 4'b1100, ready_i=0, assert rst_ni=0 for 1 cycle -> valid_o=0, busy_o=0, no clean_o,
//    next event delivered normally.
//  6 Counters (macro on, CNT_WIDTH=4): 17 delivered events -> evt_cnt_o saturates at 4'hF.

Source files
------------

// File: rtl/evt_xbar_pkg.sv
// Shared types and defaults for the event crossbar destination endpoint.
package evt_xbar_pkg;

  typedef enum logic {
    IDLE,
    DELIVER
  } evt_xbar_dst_state_e;

  localparam int unsigned EVT_XBAR_CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/evt_xbar_sat_cnt.sv
// Saturating up-counter: +1 per cycle with inc, sticks at all-ones, clear wins over inc.
// Latency 1 cycle (registered count); no backpressure.
module evt_xbar_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/evt_crossbar_dst_dev.sv
// Multicasts one upstream event to a masked set of crossbar ports; latency 1, holds until every target accepts,
// upstream stalls while held (ready_o reopens combinationally on the final handshake). Counters: EVT_XBAR_DST_CNT_EN.
module evt_crossbar_dst_dev
  import evt_xbar_pkg::*;
#(
  parameter type         T         = logic,
  parameter int unsigned SRC_PORTS = 4
`ifdef EVT_XBAR_DST_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = EVT_XBAR_CNT_WIDTH_DEF
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  T                     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [SRC_PORTS-1:0] dst_mask_i,
  output T                     data_o [SRC_PORTS],
  output logic [SRC_PORTS-1:0] valid_o,
  input  logic [SRC_PORTS-1:0] ready_i,
  output logic                 clean_o,
  output logic                 busy_o
`ifdef EVT_XBAR_DST_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] evt_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
`endif
);

  evt_xbar_dst_state_e  state_q;
  T                     data_q;
  logic [SRC_PORTS-1:0] pend_q;
  logic [SRC_PORTS-1:0] pend_nxt;
  logic                 deliver;
  logic                 last;
  logic                 accept;
  logic                 load;
  logic                 drop;

  assign deliver  = (state_q == DELIVER);
  assign pend_nxt = pend_q & ~ready_i;
  assign last     = deliver && (pend_nxt == '0);
  assign ready_o  = !deliver || last;
  assign accept   = valid_i && ready_o;
  assign load     = accept && (dst_mask_i != '0);
  assign drop     = accept && (dst_mask_i == '0);

  assign clean_o = last;
  assign busy_o  = deliver;
  assign valid_o = deliver ? pend_q : '0;

  for (genvar k = 0; k < SRC_PORTS; k++) begin : g_fanout
    assign data_o[k] = data_q;
  end

  // A final handshake and a new upstream accept may share a cycle, so load wins over retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      data_q  <= '0;
    end else if (load) begin
      state_q <= DELIVER;
      pend_q  <= dst_mask_i;
      data_q  <= data_i;
    end else if (accept || last) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else if (deliver) begin
      pend_q  <= pend_nxt;
    end
  end

`ifdef EVT_XBAR_DST_CNT_EN
  evt_xbar_sat_cnt #(.WIDTH(CNT_WIDTH)) u_evt_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (last),
    .clear  (1'b0),
    .cnt    (evt_cnt_o)
  );

  evt_xbar_sat_cnt #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (drop),
    .clear  (1'b0),
    .cnt    (drop_cnt_o)
  );
`endif

endmodule
